alu_seq_unit: RTL

Registered, handshaked 4-bit ALU execution stage that sits directly downstream of the operand-select `mux2to1`. Its `a` operand is the mux output and its `b` operand is the second operand bus. It accepts one operation at a time and executes single-cycle ops in one clock and an unsigned multiply by iterative shift-add. It holds the result and flags until the consumer takes them.

---
 rtl/alu_seq_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/alu_seq_unit.sv
// Handshaked ALU execution stage: single-cycle logic/arith ops plus an
// iterative shift-add unsigned multiply; result and flags held until consumed.
module alu_seq_unit #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               zero
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SHL   = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_PASSA = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [RW-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic [RW-1:0]   product;
  logic [CW-1:0]   count;
  logic [RW:0]     eval;

  // Packs {carry, result} for every single-cycle opcode.
  function automatic logic [RW:0] alu_eval(input logic [2:0] opc,
                                           input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y);
    logic [WIDTH:0] sum;
    logic [RW-1:0]  wide;
    logic [RW:0]    r;
    sum  = '0;
    wide = {{WIDTH{1'b0}}, x};
    r    = '0;
    case (opc)
      OP_ADD: begin
        sum = {1'b0, x} + {1'b0, y};
        r   = {sum[WIDTH], {WIDTH{1'b0}}, sum[WIDTH-1:0]};
      end
      OP_SUB: begin
        sum = {1'b0, x} - {1'b0, y};
        r   = {sum[WIDTH], {WIDTH{1'b0}}, sum[WIDTH-1:0]};
      end
      OP_AND:   r = {1'b0, {WIDTH{1'b0}}, x & y};
      OP_OR:    r = {1'b0, {WIDTH{1'b0}}, x | y};
      OP_XOR:   r = {1'b0, {WIDTH{1'b0}}, x ^ y};
      OP_SHL: begin
        if (int'(y) >= RW) r = '0;
        else               r = {1'b0, wide << y};
      end
      OP_PASSA: r = {1'b0, {WIDTH{1'b0}}, x};
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign eval     = alu_eval(op, a, b);
  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      product   <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              mcand   <= {{WIDTH{1'b0}}, a};
              mplier  <= b;
              product <= '0;
              count   <= '0;
              state   <= MUL;
            end else begin
              result    <= eval[RW-1:0];
              carry     <= eval[RW];
              zero      <= (eval[RW-1:0] == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        MUL: begin
          // One shift-add step per cycle; the extra cycle publishes the product.
          if (count == CW'(WIDTH)) begin
            result    <= product;
            carry     <= |product[RW-1:WIDTH];
            zero      <= (product == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            if (mplier[0]) product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
